// File: rtl/conbus_wrr_arb5.sv
// conbus_wrr_arb5 -- five-master weighted round-robin arbiter with watchdog.
//
// Produces the registered `gnt` select for a 5-master shared Wishbone bus.
// A master keeps the grant for up to W<n> complete transactions; the grant
// moves only at transaction boundaries, when the owner drops cyc, or when the
// watchdog decides the owner's cycle will never be acknowledged.
//
// Ports:
//   sys_clk     in   clock
//   sys_rst     in   synchronous active-high reset
//   req[4:0]    in   cyc_i of masters 4..0
//   bus_ack     in   OR of slave acks on the shared bus
//   bus_cti[2:0] in  cti of the currently granted master
//   gnt[2:0]    out  granted master index 0..4 (registered)
//   tmo         out  one-cycle pulse, watchdog expired
//   tmo_master  out  master that timed out (valid with tmo, holds otherwise)

module conbus_wrr_arb5 #(
    parameter logic [3:0]  W0         = 4'd1,
    parameter logic [3:0]  W1         = 4'd1,
    parameter logic [3:0]  W2         = 4'd1,
    parameter logic [3:0]  W3         = 4'd1,
    parameter logic [3:0]  W4         = 4'd1,
    parameter int unsigned TMO_CYCLES = 1023
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [4:0] req,
    input  logic       bus_ack,
    input  logic [2:0] bus_cti,
    output logic [2:0] gnt,
    output logic       tmo,
    output logic [2:0] tmo_master
);

    localparam logic [15:0] WD_MAX = 16'(TMO_CYCLES - 1);

    // Tenure weight of a master; a zero weight still allows one transaction.
    function automatic logic [3:0] weight(input logic [2:0] m);
        logic [3:0] w;
        case (m)
            3'd0:    w = W0;
            3'd1:    w = W1;
            3'd2:    w = W2;
            3'd3:    w = W3;
            default: w = W4;
        endcase
        return (w == 4'd0) ? 4'd1 : w;
    endfunction

    logic [2:0]  gnt_q, gnt_d;
    logic [3:0]  credit_q, credit_d;
    logic [15:0] wd_q, wd_d;
    logic [2:0]  tm_q, tm_d;

    logic       cur_req;
    logic       eot;
    logic       tmo_c;
    logic       rearb;
    logic [2:0] nxt;
    logic       found;
    logic [3:0] idx;

    assign cur_req = req[gnt_q];
    // Classic cycle (000) or end-of-burst (111) ack closes a transaction.
    assign eot     = bus_ack && (bus_cti == 3'b000 || bus_cti == 3'b111);
    assign tmo_c   = !sys_rst && cur_req && !bus_ack && (wd_q == WD_MAX);
    assign rearb   = tmo_c || !cur_req || (eot && credit_q == 4'd1);

    // Search gnt+1 .. gnt+5 (mod 5); the current owner comes last, so a lone
    // requester keeps the bus and an idle bus parks on the current owner.
    always_comb begin
        found = 1'b0;
        nxt   = gnt_q;
        idx   = 4'd0;
        for (int k = 1; k <= 5; k++) begin
            idx = {1'b0, gnt_q} + 4'(k);
            if (idx >= 4'd5) idx = idx - 4'd5;
            if (!found && req[idx[2:0]]) begin
                found = 1'b1;
                nxt   = idx[2:0];
            end
        end
    end

    always_comb begin
        gnt_d    = rearb ? nxt : gnt_q;
        credit_d = credit_q;
        if (rearb)
            credit_d = weight(gnt_d);
        else if (eot && cur_req && credit_q != 4'd0)
            credit_d = credit_q - 4'd1;
        // Watchdog only runs while the owner holds cyc waiting for an ack.
        if (tmo_c || !cur_req || bus_ack || gnt_d != gnt_q)
            wd_d = 16'd0;
        else
            wd_d = wd_q + 16'd1;
        tm_d = tmo_c ? gnt_q : tm_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            gnt_q    <= 3'd0;
            credit_q <= weight(3'd0);
            wd_q     <= 16'd0;
            tm_q     <= 3'd0;
        end else begin
            gnt_q    <= gnt_d;
            credit_q <= credit_d;
            wd_q     <= wd_d;
            tm_q     <= tm_d;
        end
    end

    assign gnt        = gnt_q;
    assign tmo        = tmo_c;
    assign tmo_master = tm_d;

endmodule
